// File: rtl/ltl_cluster_ctrl.sv
// ltl_cluster_ctrl: sequences a 10-property LTL monitor cluster, tags its hits with symbol
// sequence numbers and reports them to the host one at a time, round-robin.
module ltl_cluster_ctrl #(
  parameter int N_PROP    = 10,
  parameter int SYM_W     = 8,
  parameter int SEQ_W     = 16,
  parameter int HIT_LAT   = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [N_PROP-1:0] cfg_mask,
  input  logic              flush_req,
  input  logic              sticky_clr,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [SYM_W-1:0]  sym_in,
  output logic              mon_run,
  output logic [SYM_W-1:0]  mon_symbols,
  output logic              mon_reset,
  input  logic [N_PROP-1:0] ltl_hit,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [3:0]        rpt_id,
  output logic [SEQ_W-1:0]  rpt_seq,
  output logic [N_PROP-1:0] viol_sticky,
  output logic              ovf_sticky
);
  localparam logic [1:0] S_IDLE = 2'd0, S_FLUSH = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3;
  localparam int CNT_W = $clog2(FLUSH_CYC > HIT_LAT ? FLUSH_CYC : HIT_LAT) + 1;
  localparam int ID_W = 4;
  localparam int SUM_W = ID_W + 1;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               mon_run_q, mon_run_d;
  logic [SYM_W-1:0]   mon_sym_q, mon_sym_d;
  logic [SEQ_W-1:0]   mon_seq_q, mon_seq_d;
  logic [HIT_LAT-1:0] dly_run_q, dly_run_d;
  logic [SEQ_W-1:0]   dly_seq_q [HIT_LAT];
  logic [SEQ_W-1:0]   dly_seq_d [HIT_LAT];
  logic [N_PROP-1:0]  pend_q, pend_d, viol_q, viol_d;
  logic               ovf_q, ovf_d;
  logic [SEQ_W-1:0]   slot_q [N_PROP];
  logic [SEQ_W-1:0]   slot_d [N_PROP];
  logic               rpt_valid_q, rpt_valid_d;
  logic [ID_W-1:0]    rpt_id_q, rpt_id_d, rr_q, rr_d;
  logic [SEQ_W-1:0]   rpt_seq_q, rpt_seq_d;
  logic               accept, hs, take, gnt_v;
  logic [N_PROP-1:0]  clr, hit, avail, rot;
  logic [ID_W-1:0]    off, gnt_id;
  logic [SUM_W-1:0]   sum;
  assign sym_ready   = state_q == S_RUN;
  assign accept      = sym_valid & sym_ready;
  assign mon_reset   = state_q == S_FLUSH;
  assign mon_run     = mon_run_q;
  assign mon_symbols = mon_sym_q;
  assign rpt_valid   = rpt_valid_q;
  assign rpt_id      = rpt_id_q;
  assign rpt_seq     = rpt_seq_q;
  assign viol_sticky = viol_q;
  assign ovf_sticky  = ovf_q;
  assign hs          = rpt_valid_q & rpt_ready;
  assign clr         = hs ? N_PROP'(1) << rpt_id_q : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = accept ? seq_q + SEQ_W'(1) : seq_q;
    case (state_q)
      S_IDLE: if (cfg_enable) begin
        state_d = S_FLUSH;
        cnt_d   = '0;
      end
      S_FLUSH: begin
        seq_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) state_d = S_RUN;
      end
      S_RUN: if (flush_req || !cfg_enable) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      default: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HIT_LAT - 1)) begin
          state_d = cfg_enable ? S_FLUSH : S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end
  // The issued symbol's seq travels with mon_run so each hit is tagged with its cause.
  always_comb begin
    mon_run_d    = accept;
    mon_sym_d    = accept ? sym_in : mon_sym_q;
    mon_seq_d    = accept ? seq_q : mon_seq_q;
    dly_run_d    = dly_run_q;
    dly_seq_d    = dly_seq_q;
    dly_run_d[0] = mon_run_q;
    dly_seq_d[0] = mon_seq_q;
    for (int k = 1; k < HIT_LAT; k++) begin
      dly_run_d[k] = dly_run_q[k-1];
      dly_seq_d[k] = dly_seq_q[k-1];
    end
  end
  always_comb begin
    hit    = dly_run_q[HIT_LAT-1] ? ltl_hit & cfg_mask : '0;
    pend_d = pend_q;
    slot_d = slot_q;
    viol_d = (sticky_clr ? '0 : viol_q) | hit;
    ovf_d  = ovf_q & ~sticky_clr;
    for (int i = 0; i < N_PROP; i++) begin
      if (hit[i] && (!pend_q[i] || clr[i])) begin
        pend_d[i] = 1'b1;
        slot_d[i] = dly_seq_q[HIT_LAT-1];
      end else begin
        if (hit[i]) ovf_d = 1'b1;
        if (clr[i]) pend_d[i] = 1'b0;
      end
    end
  end
  // Rotate pending so bit 0 is rr_ptr; the lowest set bit is the next grant.
  always_comb begin
    rr_d  = hs ? (rpt_id_q == ID_W'(N_PROP - 1) ? '0 : rpt_id_q + ID_W'(1)) : rr_q;
    avail = pend_q & ~clr;
    rot   = N_PROP'({avail, avail} >> rr_d);
    gnt_v = 1'b0;
    off   = '0;
    for (int k = N_PROP - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_v = 1'b1;
        off   = ID_W'(k);
      end
    end
    sum         = {1'b0, rr_d} + {1'b0, off};
    gnt_id      = sum >= SUM_W'(N_PROP) ? ID_W'(sum - SUM_W'(N_PROP)) : ID_W'(sum);
    take        = !rpt_valid_q || rpt_ready;
    rpt_valid_d = take ? gnt_v : rpt_valid_q;
    rpt_id_d    = take && gnt_v ? gnt_id : rpt_id_q;
    rpt_seq_d   = take && gnt_v ? slot_q[gnt_id] : rpt_seq_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seq_q       <= '0;
      mon_run_q   <= 1'b0;
      mon_sym_q   <= '0;
      mon_seq_q   <= '0;
      dly_run_q   <= '0;
      dly_seq_q   <= '{default: '0};
      pend_q      <= '0;
      slot_q      <= '{default: '0};
      viol_q      <= '0;
      ovf_q       <= 1'b0;
      rr_q        <= '0;
      rpt_valid_q <= 1'b0;
      rpt_id_q    <= '0;
      rpt_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      mon_run_q   <= mon_run_d;
      mon_sym_q   <= mon_sym_d;
      mon_seq_q   <= mon_seq_d;
      dly_run_q   <= dly_run_d;
      dly_seq_q   <= dly_seq_d;
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      viol_q      <= viol_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_id_q    <= rpt_id_d;
      rpt_seq_q   <= rpt_seq_d;
    end
  end
endmodule
